// File: rtl/bcd_converter_if.sv
// ---------------------------------------------------------------------------
// bcd_converter_if
// Handshake and data bundle for the binary-to-BCD converter.
//   start        : request a conversion of bin_in (requester -> converter)
//   bin_in[7:0]  : binary value, unsigned or two's complement
//   signed_mode  : 1 = bin_in is two's complement
//   ovf_in       : upstream overflow flag, captured with bin_in
//   bcd_out[11:0]: {hundreds, tens, ones} BCD of the magnitude
//   neg_out      : completed result was negative
//   err_out      : captured ovf_in of the completed conversion
//   busy         : conversion in progress
//   done         : one-cycle pulse, outputs just updated
// master = requester side, slave = converter side.
// ---------------------------------------------------------------------------
interface bcd_converter_if;
  logic        start;
  logic [7:0]  bin_in;
  logic        signed_mode;
  logic        ovf_in;
  logic [11:0] bcd_out;
  logic        neg_out;
  logic        err_out;
  logic        busy;
  logic        done;

  modport master (
    output start, bin_in, signed_mode, ovf_in,
    input  bcd_out, neg_out, err_out, busy, done
  );

  modport slave (
    input  start, bin_in, signed_mode, ovf_in,
    output bcd_out, neg_out, err_out, busy, done
  );
endinterface

// File: rtl/bcd_converter.sv
// ---------------------------------------------------------------------------
// bcd_converter
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// A start in IDLE or DONE captures the operands; SHIFT runs for exactly
// 8 cycles; DONE presents the result with a one-cycle done pulse. A start
// held during DONE chains a new conversion (9-cycle period). Starts seen
// during SHIFT are ignored.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset, overrides start
//   bus   : bcd_converter_if.slave (start/bin_in/signed_mode/ovf_in in,
//           bcd_out/neg_out/err_out/busy/done out, all outputs registered)
// ---------------------------------------------------------------------------
module bcd_converter (
  input logic            clk,
  input logic            rst_n,
  bcd_converter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [7:0]  mag;       // magnitude being shifted out MSB first
  logic [11:0] scratch;   // BCD digits under construction
  logic [2:0]  cnt;       // SHIFT step counter, 0..7
  logic        neg_q;
  logic        err_q;

  logic [7:0]  mag_abs;
  logic [11:0] dab;
  logic [11:0] scratch_next;

  // Correct a digit so that the following doubling carries into the next
  // decade instead of leaving a non-decimal value.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Two's complement negate; 0x80 maps to 0x80, i.e. 128 as unsigned.
  assign mag_abs = (bus.signed_mode & bus.bin_in[7]) ? (~bus.bin_in + 8'd1)
                                                     : bus.bin_in;

  // NOTE: every always_comb output is assigned on every path, so no latch.
  always_comb begin
    dab          = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
    // dab[11] is always 0 here: the hundreds digit never exceeds 2.
    scratch_next = {dab[10:0], mag[7]};
  end

  // NOTE: sequential state uses non-blocking assignments only, and reset is
  // sampled on the clock edge (synchronous), taking priority over start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mag         <= '0;
      scratch     <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      bus.bcd_out <= '0;
      bus.neg_out <= 1'b0;
      bus.err_out <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            mag      <= mag_abs;
            // A zero input has bin_in[7]=0, so it is never flagged negative.
            neg_q    <= bus.signed_mode & bus.bin_in[7];
            err_q    <= bus.ovf_in;
            scratch  <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end else begin
            state    <= IDLE;
          end
        end

        SHIFT: begin
          scratch <= scratch_next;
          mag     <= {mag[6:0], 1'b0};
          cnt     <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            // Last step: publish the fully shifted digits directly so the
            // outputs never expose a partial result.
            bus.bcd_out <= scratch_next;
            bus.neg_out <= neg_q;
            bus.err_out <= err_q;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            state       <= DONE;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule
